dpram_arbiter: RTL and testbench

DPRAM_ARBITER -- requirements
Module: dpram_arbiter

---
 rtl/dpram_arbiter_pkg.sv | 24 ++
 rtl/dpram_arbiter_if.sv | 43 ++++
 rtl/dpram_arbiter_rr_pick4.sv | 41 ++++
 rtl/dpram_arbiter.sv | 147 ++++++++++++++
 tb/tb_dpram_arbiter.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dpram_arbiter_pkg.sv
// ------------------------------------------------------------------
// dpram_arbiter_pkg : shared constants and types for dpram_arbiter
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package dpram_arbiter_pkg;

  localparam int NREQ       = 4;
  localparam int DW         = 8;
  localparam int AW         = 6;
  localparam int IDX_W      = 2;
  localparam int CNT_W      = AW - 1;
  localparam int ADDR_BUS_W = NREQ * AW;
  localparam int DATA_BUS_W = NREQ * DW;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

endpackage

`default_nettype wire

// File: rtl/dpram_arbiter_if.sv
// ------------------------------------------------------------------
// dpram_arbiter_if : requester bus and external RAM port bundle
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

interface dpram_arbiter_if;
  import dpram_arbiter_pkg::*;

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_we;
  logic [ADDR_BUS_W-1:0] req_addr;
  logic [DATA_BUS_W-1:0] req_wdata;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       rsp_valid;
  logic [DATA_BUS_W-1:0] rsp_data;
  logic [AW-1:0]         ram_addr_a;
  logic [AW-1:0]         ram_addr_b;
  logic [DW-1:0]         ram_data_a;
  logic [DW-1:0]         ram_data_b;
  logic                  ram_we_a;
  logic                  ram_we_b;
  logic [DW-1:0]         ram_q_a;
  logic [DW-1:0]         ram_q_b;
  logic                  init_done;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, ram_q_a, ram_q_b,
    output req_ready, rsp_valid, rsp_data,
    output ram_addr_a, ram_addr_b, ram_data_a, ram_data_b, ram_we_a, ram_we_b,
    output init_done
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, ram_q_a, ram_q_b,
    input  req_ready, rsp_valid, rsp_data,
    input  ram_addr_a, ram_addr_b, ram_data_a, ram_data_b, ram_we_a, ram_we_b,
    input  init_done
  );

endinterface

`default_nettype wire

// File: rtl/dpram_arbiter_rr_pick4.sv
// ------------------------------------------------------------------
// rr_pick4 : first and second eligible requester from a rotating start
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module rr_pick4 (
  input  logic [3:0]      mask,
  input  logic [1:0]      ptr,
  input  logic [3:0][3:0] compat,
  output logic            first_vld,
  output logic [1:0]      first_idx,
  output logic            second_vld,
  output logic [1:0]      second_idx
);

  // compat[f][j] says requester j may share the cycle with requester f
  always_comb begin
    logic [1:0] idx;
    first_vld  = 1'b0;
    first_idx  = '0;
    second_vld = 1'b0;
    second_idx = '0;
    idx        = '0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (mask[idx]) begin
        if (!first_vld) begin
          first_vld = 1'b1;
          first_idx = idx;
        end else if (!second_vld && compat[first_idx][idx]) begin
          second_vld = 1'b1;
          second_idx = idx;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/dpram_arbiter.sv
// ------------------------------------------------------------------
// dpram_arbiter : 4-requester round-robin arbiter onto a dual-port RAM
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module dpram_arbiter
  import dpram_arbiter_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  dpram_arbiter_if.slave  bus
);

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [IDX_W-1:0]          ptr_q, ptr_d;
  logic [IDX_W-1:0]          own_a_q, own_a_d, own_b_q, own_b_d;
  logic                      rd_a_q, rd_a_d, rd_b_q, rd_b_d;

  logic [AW-1:0]             addr  [NREQ];
  logic [DW-1:0]             wdata [NREQ];
  logic [NREQ-1:0][NREQ-1:0] compat;
  logic [NREQ-1:0]           pick_mask;
  logic                      a_vld, b_vld;
  logic [IDX_W-1:0]          a_idx, b_idx;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign addr[i]  = bus.req_addr[i*AW +: AW];
    assign wdata[i] = bus.req_wdata[i*DW +: DW];
  end

  // Same address with any write among the pair cannot share a cycle
  always_comb begin
    compat = '0;
    for (int i = 0; i < NREQ; i++) begin
      for (int j = 0; j < NREQ; j++) begin
        compat[i][j] = !((addr[i] == addr[j]) && (bus.req_we[i] || bus.req_we[j]));
      end
    end
  end

  assign pick_mask = (state_q == RUN) ? bus.req_valid : '0;

  rr_pick4 u_pick (
    .mask       (pick_mask),
    .ptr        (ptr_q),
    .compat     (compat),
    .first_vld  (a_vld),
    .first_idx  (a_idx),
    .second_vld (b_vld),
    .second_idx (b_idx)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      ptr_q   <= '0;
      own_a_q <= '0;
      own_b_q <= '0;
      rd_a_q  <= 1'b0;
      rd_b_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      own_a_q <= own_a_d;
      own_b_q <= own_b_d;
      rd_a_q  <= rd_a_d;
      rd_b_q  <= rd_b_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = RUN;
      end
      RUN:     cnt_d   = '0;
      default: state_d = CLEAR;
    endcase
  end

  always_comb begin
    bus.req_ready  = '0;
    bus.ram_we_a   = 1'b0;
    bus.ram_addr_a = '0;
    bus.ram_data_a = '0;
    bus.ram_we_b   = 1'b0;
    bus.ram_addr_b = '0;
    bus.ram_data_b = '0;
    ptr_d          = ptr_q;
    own_a_d        = '0;
    own_b_d        = '0;
    rd_a_d         = 1'b0;
    rd_b_d         = 1'b0;
    if (state_q == CLEAR) begin
      // Port A sweeps the lower half, port B the upper half
      bus.ram_we_a   = 1'b1;
      bus.ram_addr_a = {1'b0, cnt_q};
      bus.ram_we_b   = 1'b1;
      bus.ram_addr_b = {1'b1, cnt_q};
    end else begin
      if (a_vld) begin
        bus.req_ready[a_idx] = 1'b1;
        bus.ram_we_a         = bus.req_we[a_idx];
        bus.ram_addr_a       = addr[a_idx];
        bus.ram_data_a       = bus.req_we[a_idx] ? wdata[a_idx] : '0;
        own_a_d              = a_idx;
        rd_a_d               = !bus.req_we[a_idx];
        ptr_d                = a_idx + 1'b1;
      end
      if (b_vld) begin
        bus.req_ready[b_idx] = 1'b1;
        bus.ram_we_b         = bus.req_we[b_idx];
        bus.ram_addr_b       = addr[b_idx];
        bus.ram_data_b       = bus.req_we[b_idx] ? wdata[b_idx] : '0;
        own_b_d              = b_idx;
        rd_b_d               = !bus.req_we[b_idx];
        ptr_d                = b_idx + 1'b1;
      end
    end
  end

  always_comb begin
    bus.rsp_valid = '0;
    bus.rsp_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if ((state_q == RUN) && rd_a_q && (own_a_q == IDX_W'(i))) begin
        bus.rsp_valid[i]          = 1'b1;
        bus.rsp_data[i*DW +: DW]  = bus.ram_q_a;
      end else if ((state_q == RUN) && rd_b_q && (own_b_q == IDX_W'(i))) begin
        bus.rsp_valid[i]          = 1'b1;
        bus.rsp_data[i*DW +: DW]  = bus.ram_q_b;
      end
    end
  end

  assign bus.init_done = (state_q == RUN);

endmodule

`default_nettype wire

// File: tb/tb_dpram_arbiter.sv
// ------------------------------------------------------------------
// tb_dpram_arbiter : directed and random checks of dpram_arbiter
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_dpram_arbiter;
  import dpram_arbiter_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dpram_arbiter_if bus ();

  dpram_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // External RAM: synchronous write, registered read on each port
  logic [DW-1:0] ram [64];
  always @(posedge clk) begin
    if (bus.ram_we_a) ram[bus.ram_addr_a] <= bus.ram_data_a;
    if (bus.ram_we_b) ram[bus.ram_addr_b] <= bus.ram_data_b;
    bus.ram_q_a <= ram[bus.ram_addr_a];
    bus.ram_q_b <= ram[bus.ram_addr_b];
  end

  int checks = 0;
  int errors = 0;

  // Requester stimulus
  bit   [3:0]    t_valid;
  bit   [3:0]    t_we;
  logic [AW-1:0] t_addr  [4];
  logic [DW-1:0] t_wdata [4];

  // Reference model state
  bit   [1:0]    m_ptr;
  bit            m_run;
  logic [DW-1:0] mem_ref [64];
  bit   [3:0]    exp_rv;
  logic [DW-1:0] exp_rd  [4];

  task automatic chk(input string tag, input string what,
                     input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, what, obs, exp);
    end
  endtask

  task automatic apply();
    bus.req_valid = t_valid;
    bus.req_we    = t_we;
    for (int i = 0; i < 4; i++) begin
      bus.req_addr[i*AW +: AW]  = t_addr[i];
      bus.req_wdata[i*DW +: DW] = t_wdata[i];
    end
  endtask

  // One RUN cycle: predict grants, check mid-cycle, advance model at the edge
  task automatic run_cycle(input string tag, input bit rst_at_edge,
                           output bit [3:0] g, output logic [3:0] o_rdy,
                           output logic [3:0] o_rv, output logic [31:0] o_rd);
    bit av, bv;
    int ai, bi;
    bit [3:0] new_rv;
    logic [31:0] erd;
    apply();
    av = 0; bv = 0; ai = 0; bi = 0;
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (int'(m_ptr) + k) % 4;
      if (t_valid[i]) begin
        if (!av) begin
          av = 1; ai = i;
        end else if (!bv && !((t_addr[i] == t_addr[ai]) && (t_we[i] || t_we[ai]))) begin
          bv = 1; bi = i;
        end
      end
    end
    g = '0;
    if (av) g[ai] = 1'b1;
    if (bv) g[bi] = 1'b1;
    erd = '0;
    for (int i = 0; i < 4; i++) erd[i*8 +: 8] = exp_rv[i] ? exp_rd[i] : 8'h00;

    #4;
    o_rdy = bus.req_ready;
    o_rv  = bus.rsp_valid;
    o_rd  = bus.rsp_data;
    chk(tag, "req_ready",  bus.req_ready, g);
    chk(tag, "init_done",  bus.init_done, m_run);
    chk(tag, "we_a",       bus.ram_we_a,  av ? t_we[ai] : 1'b0);
    chk(tag, "addr_a",     bus.ram_addr_a, av ? t_addr[ai] : 6'd0);
    if (!av || t_we[ai]) chk(tag, "data_a", bus.ram_data_a, av ? t_wdata[ai] : 8'd0);
    chk(tag, "we_b",       bus.ram_we_b,  bv ? t_we[bi] : 1'b0);
    chk(tag, "addr_b",     bus.ram_addr_b, bv ? t_addr[bi] : 6'd0);
    if (!bv || t_we[bi]) chk(tag, "data_b", bus.ram_data_b, bv ? t_wdata[bi] : 8'd0);
    chk(tag, "rsp_valid",  bus.rsp_valid, exp_rv);
    chk(tag, "rsp_data",   bus.rsp_data,  erd);
    if (rst_at_edge) rst_n = 1'b0;

    @(posedge clk);
    if (rst_at_edge) begin
      m_ptr = 0; m_run = 0; exp_rv = '0;
    end else begin
      new_rv = '0;
      if (av && !t_we[ai]) begin new_rv[ai] = 1; exp_rd[ai] = mem_ref[t_addr[ai]]; end
      if (bv && !t_we[bi]) begin new_rv[bi] = 1; exp_rd[bi] = mem_ref[t_addr[bi]]; end
      if (av && t_we[ai]) mem_ref[t_addr[ai]] = t_wdata[ai];
      if (bv && t_we[bi]) mem_ref[t_addr[bi]] = t_wdata[bi];
      exp_rv = new_rv;
      if (av) m_ptr = 2'((bv ? bi : ai) + 1);
    end
    #1;
  endtask

  // Entered with reset already sampled low at the last edge
  task automatic reset_hold_and_sweep();
    for (int c = 0; c < 2; c++) begin
      t_valid = 4'($urandom);
      apply();
      #4;
      chk("rst_hold", "req_ready", bus.req_ready, 4'b0000);
      chk("rst_hold", "rsp_valid", bus.rsp_valid, 4'b0000);
      chk("rst_hold", "rsp_data",  bus.rsp_data,  32'h0);
      chk("rst_hold", "init_done", bus.init_done, 1'b0);
      chk("rst_hold", "addr_a",    bus.ram_addr_a, 6'd0);
      chk("rst_hold", "addr_b",    bus.ram_addr_b, 6'd32);
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 32; k++) begin
      t_valid = 4'($urandom);
      t_we    = 4'($urandom);
      apply();
      #4;
      chk("sweep", "req_ready", bus.req_ready, 4'b0000);
      chk("sweep", "init_done", bus.init_done, 1'b0);
      chk("sweep", "rsp_valid", bus.rsp_valid, 4'b0000);
      chk("sweep", "we_a",      bus.ram_we_a,  1'b1);
      chk("sweep", "addr_a",    bus.ram_addr_a, 32'(k));
      chk("sweep", "data_a",    bus.ram_data_a, 8'd0);
      chk("sweep", "we_b",      bus.ram_we_b,  1'b1);
      chk("sweep", "addr_b",    bus.ram_addr_b, 32'(k + 32));
      chk("sweep", "data_b",    bus.ram_data_b, 8'd0);
      @(posedge clk); #1;
    end
    m_run = 1; m_ptr = 0; exp_rv = '0;
    for (int a = 0; a < 64; a++) mem_ref[a] = '0;
    t_valid = '0;
    t_we    = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit   [3:0]  g;
    logic [3:0]  rdy, rv;
    logic [31:0] rd;
    bit   [3:0]  fair_exp [4];
    fair_exp = '{4'b1100, 4'b0011, 4'b1100, 4'b0011};
    t_valid = '0; t_we = '0; m_ptr = 0; m_run = 0; exp_rv = '0;
    for (int i = 0; i < 4; i++) begin t_addr[i] = '0; t_wdata[i] = '0; exp_rd[i] = '0; end
    apply();
    rst_n = 1'b0;
    @(posedge clk); #1;
    reset_hold_and_sweep();

    // Write/read conflict on address 9, pointer at 0
    t_valid = 4'b0101; t_we = 4'b0001;
    t_addr[0] = 6'd9; t_wdata[0] = 8'hA5; t_addr[2] = 6'd9;
    run_cycle("conf0", 0, g, rdy, rv, rd);
    chk("conf0", "ready_dir", rdy, 4'b0001);
    t_valid = 4'b0100;
    run_cycle("conf1", 0, g, rdy, rv, rd);
    chk("conf1", "ready_dir", rdy, 4'b0100);
    t_valid = 4'b0000;
    run_cycle("conf2", 0, g, rdy, rv, rd);
    chk("conf2", "rsp_valid_dir", rv, 4'b0100);
    chk("conf2", "rsp_data2_dir", rd[23:16], 8'hA5);

    // Requester 3 stores 0x3C at 5, returning the pointer to 0
    t_valid = 4'b1000; t_we = 4'b1000; t_addr[3] = 6'd5; t_wdata[3] = 8'h3C;
    run_cycle("align", 0, g, rdy, rv, rd);
    chk("align", "ready_dir", rdy, 4'b1000);

    // Two reads of the same address share the cycle
    t_valid = 4'b0011; t_we = 4'b0000; t_addr[0] = 6'd5; t_addr[1] = 6'd5;
    run_cycle("dual", 0, g, rdy, rv, rd);
    chk("dual", "ready_dir", rdy, 4'b0011);
    t_valid = 4'b0000;
    run_cycle("dual_rsp", 0, g, rdy, rv, rd);
    chk("dual_rsp", "rsp_valid_dir", rv, 4'b0011);
    chk("dual_rsp", "rsp_data_dir", rd[15:0], 16'h3C3C);
    run_cycle("idle", 0, g, rdy, rv, rd);

    // All four read distinct addresses; pointer starts at 2 after idling
    t_valid = 4'b1111; t_we = 4'b0000;
    for (int i = 0; i < 4; i++) t_addr[i] = 6'(10 + i);
    for (int c = 0; c < 4; c++) begin
      run_cycle("fair", 0, g, rdy, rv, rd);
      chk("fair", "ready_dir", rdy, fair_exp[c]);
    end

    // Reset on the edge right after a read grant
    t_valid = 4'b0010; t_we = 4'b0000;
    run_cycle("midrst", 1, g, rdy, rv, rd);
    chk("midrst", "ready_dir", rdy, 4'b0010);
    reset_hold_and_sweep();

    // Random traffic over a small address window to provoke conflicts
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (!t_valid[i] && ($urandom_range(0, 1) == 1)) begin
          t_valid[i] = 1'b1;
          t_we[i]    = ($urandom_range(0, 2) == 0);
          t_addr[i]  = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'($urandom_range(0, 3));
          t_wdata[i] = 8'($urandom);
        end
      end
      run_cycle("rand", 0, g, rdy, rv, rd);
      t_valid = t_valid & ~g;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
